// File: rtl/uart_rx_os_if.sv
// Word delivery channel between the oversampling UART receiver and its consumer.
// The receiver owns the holding register (master); the consumer drives i_ready (slave).
interface uart_rx_os_if #(
    parameter int MAX_WORD = 9
) ();
    logic [MAX_WORD-1:0] o_data;
    logic                o_valid;
    logic                i_ready;
    logic                o_parity_err;
    logic                o_frame_err;

    modport master (
        output o_data,
        output o_valid,
        output o_parity_err,
        output o_frame_err,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        input  o_parity_err,
        input  o_frame_err,
        output i_ready
    );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchronised RX line, 3-sample mid-bit majority vote,
// configurable word size / parity / stop bits, valid-ready holding register with
// parity, framing, break and overrun reporting.
module uart_rx_os #(
    parameter int OVERSAMPLE  = 16,
    parameter int MAX_WORD    = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_sample_tick,
    input  logic         i_rx,
    input  logic         i_cfg_store,
    input  logic [4:0]   i_cfg_word_size,
    input  logic         i_cfg_parity_en,
    input  logic         i_cfg_parity_odd,
    input  logic         i_cfg_two_stop,
    uart_rx_os_if.master rx_bus,
    output logic         o_break,
    output logic         o_overrun,
    output logic         o_busy
);
    localparam int             TCW     = $clog2(OVERSAMPLE);
    localparam int             M       = OVERSAMPLE / 2;
    localparam logic [TCW-1:0] TC_S0   = TCW'(M - 1);
    localparam logic [TCW-1:0] TC_S1   = TCW'(M);
    localparam logic [TCW-1:0] TC_DEC  = TCW'(M + 1);
    localparam logic [TCW-1:0] TC_LAST = TCW'(OVERSAMPLE - 1);
    localparam logic [4:0]     WS_MIN  = 5'd5;
    localparam logic [4:0]     WS_MAX  = 5'(MAX_WORD);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5,
        ST_WAIT   = 3'd6
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Even parity: data ^ parity bit must be 0; odd parity: must be 1.
    function automatic logic parity_mismatch(input logic [MAX_WORD-1:0] d,
                                             input logic p, input logic odd);
        return ((^d) ^ p) != odd;
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rx_s;
    state_t                 state_r, state_nxt;
    logic [TCW-1:0]         tc_r;
    logic [4:0]             idx_r;
    logic [MAX_WORD-1:0]    data_r;
    logic                   s0_r, s1_r, par_bit_r, stop1_err_r;
    logic [4:0]             cfg_ws_r;
    logic                   cfg_pe_r, cfg_po_r, cfg_ts_r;
    logic [4:0]             cfg_ws_in_s;
    logic                   dec_s, wrap_s, vote_s, last_bit_s, brk_cond_s, accept_s;
    logic                   start_s, shift_s, idx_inc_s, par_cap_s, stop1_cap_s;
    logic                   done_s, brk_s, ferr_s;
    logic [MAX_WORD-1:0]    hold_data_r;
    logic                   hold_valid_r, hold_perr_r, hold_ferr_r;
    logic                   break_r, overrun_r, busy_r;

    assign rx_s        = sync_r[SYNC_STAGES-1];
    assign dec_s       = i_sample_tick & (tc_r == TC_DEC);
    assign wrap_s      = i_sample_tick & (tc_r == TC_LAST);
    assign vote_s      = maj3(s0_r, s1_r, rx_s);
    assign last_bit_s  = (idx_r == (cfg_ws_r - 5'd1));
    assign brk_cond_s  = (data_r == {MAX_WORD{1'b0}}) & (~cfg_pe_r | ~par_bit_r) & ~vote_s;
    assign accept_s    = hold_valid_r & rx_bus.i_ready;
    assign cfg_ws_in_s = (i_cfg_word_size < WS_MIN) ? WS_MIN :
                         (i_cfg_word_size > WS_MAX) ? WS_MAX : i_cfg_word_size;

    // Bring the asynchronous line into the clock domain; idle level is high.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) sync_r <= {SYNC_STAGES{1'b1}};
        else          sync_r <= {sync_r[SYNC_STAGES-2:0], i_rx};
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_r <= ST_IDLE;
        else          state_r <= state_nxt;
    end

    // Next state and per-tick control strobes for the datapath.
    always_comb begin
        state_nxt   = state_r;
        start_s     = 1'b0;
        shift_s     = 1'b0;
        idx_inc_s   = 1'b0;
        par_cap_s   = 1'b0;
        stop1_cap_s = 1'b0;
        done_s      = 1'b0;
        brk_s       = 1'b0;
        ferr_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_sample_tick && !rx_s) begin
                    state_nxt = ST_START;
                    start_s   = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (dec_s && vote_s)  state_nxt = ST_IDLE;
                else if (wrap_s)      state_nxt = ST_DATA;
                else                  state_nxt = ST_START;
            end
            ST_DATA: begin
                shift_s = dec_s;
                if (wrap_s && last_bit_s) begin
                    state_nxt = cfg_pe_r ? ST_PARITY : ST_STOP1;
                end else if (wrap_s) begin
                    idx_inc_s = 1'b1;
                    state_nxt = ST_DATA;
                end else begin
                    state_nxt = ST_DATA;
                end
            end
            ST_PARITY: begin
                par_cap_s = dec_s;
                if (wrap_s) state_nxt = ST_STOP1;
                else        state_nxt = ST_PARITY;
            end
            ST_STOP1: begin
                if (dec_s && brk_cond_s) begin
                    brk_s     = 1'b1;
                    state_nxt = ST_WAIT;
                end else if (dec_s && cfg_ts_r) begin
                    stop1_cap_s = 1'b1;
                    state_nxt   = ST_STOP1;
                end else if (dec_s) begin
                    // Leave mid-stop so the next start edge can be caught early.
                    done_s    = 1'b1;
                    ferr_s    = ~vote_s;
                    state_nxt = vote_s ? ST_IDLE : ST_WAIT;
                end else if (wrap_s && cfg_ts_r) begin
                    state_nxt = ST_STOP2;
                end else begin
                    state_nxt = ST_STOP1;
                end
            end
            ST_STOP2: begin
                if (dec_s) begin
                    done_s    = 1'b1;
                    ferr_s    = stop1_err_r | ~vote_s;
                    state_nxt = ferr_s ? ST_WAIT : ST_IDLE;
                end else begin
                    state_nxt = ST_STOP2;
                end
            end
            ST_WAIT: begin
                if (i_sample_tick && rx_s) state_nxt = ST_IDLE;
                else                       state_nxt = ST_WAIT;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Tick counter: the start-detect tick is tc=0, held at 0 outside a frame.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            tc_r <= {TCW{1'b0}};
        else if (state_r == ST_IDLE || state_nxt == ST_IDLE || state_nxt == ST_WAIT)
            tc_r <= {TCW{1'b0}};
        else if (i_sample_tick)
            tc_r <= (tc_r == TC_LAST) ? {TCW{1'b0}} : tc_r + TCW'(1);
        else
            tc_r <= tc_r;
    end

    // Capture the two early vote samples; the third is the live line at decision.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s0_r <= 1'b1;
            s1_r <= 1'b1;
        end else begin
            if (i_sample_tick && tc_r == TC_S0) s0_r <= rx_s;
            if (i_sample_tick && tc_r == TC_S1) s1_r <= rx_s;
        end
    end

    // Frame datapath: bit index, LSB-first data assembly, parity and first stop.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || start_s) begin
            idx_r       <= 5'd0;
            data_r      <= {MAX_WORD{1'b0}};
            par_bit_r   <= 1'b0;
            stop1_err_r <= 1'b0;
        end else begin
            if (idx_inc_s)   idx_r       <= idx_r + 5'd1;
            if (shift_s)     data_r      <= data_r | ({{(MAX_WORD-1){1'b0}}, vote_s} << idx_r);
            if (par_cap_s)   par_bit_r   <= vote_s;
            if (stop1_cap_s) stop1_err_r <= ~vote_s;
        end
    end

    // Configuration, accepted only between frames.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cfg_ws_r <= 5'd8;
            cfg_pe_r <= 1'b0;
            cfg_po_r <= 1'b0;
            cfg_ts_r <= 1'b0;
        end else if (i_cfg_store && state_r == ST_IDLE) begin
            cfg_ws_r <= cfg_ws_in_s;
            cfg_pe_r <= i_cfg_parity_en;
            cfg_po_r <= i_cfg_parity_odd;
            cfg_ts_r <= i_cfg_two_stop;
        end
    end

    // Holding register, overrun tracking and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hold_data_r  <= {MAX_WORD{1'b0}};
            hold_valid_r <= 1'b0;
            hold_perr_r  <= 1'b0;
            hold_ferr_r  <= 1'b0;
            overrun_r    <= 1'b0;
            break_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            if (done_s && (!hold_valid_r || rx_bus.i_ready)) begin
                hold_data_r  <= data_r;
                hold_valid_r <= 1'b1;
                hold_perr_r  <= cfg_pe_r & parity_mismatch(data_r, par_bit_r, cfg_po_r);
                hold_ferr_r  <= ferr_s;
            end else if (accept_s) begin
                hold_valid_r <= 1'b0;
            end
            if (accept_s)                    overrun_r <= 1'b0;
            else if (done_s && hold_valid_r) overrun_r <= 1'b1;
            break_r <= brk_s;
            busy_r  <= (state_nxt != ST_IDLE);
        end
    end

    assign rx_bus.o_data       = hold_data_r;
    assign rx_bus.o_valid      = hold_valid_r;
    assign rx_bus.o_parity_err = hold_perr_r;
    assign rx_bus.o_frame_err  = hold_ferr_r;
    assign o_break             = break_r;
    assign o_overrun           = overrun_r;
    assign o_busy              = busy_r;
endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: frames are generated from a word-level model,
// expected words are queued at issue time and checked by an independent monitor.
module tb_uart_rx_os;
    localparam int OS = 16;
    localparam int MW = 9;

    logic       clk = 1'b0;
    logic       rst_n, tick, rx, cfg_store, cfg_pe, cfg_po, cfg_ts;
    logic [4:0] cfg_ws;
    logic       brk, overrun, busy;

    uart_rx_os_if #(.MAX_WORD(MW)) bus ();

    uart_rx_os #(.OVERSAMPLE(OS), .MAX_WORD(MW), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample_tick(tick), .i_rx(rx),
        .i_cfg_store(cfg_store), .i_cfg_word_size(cfg_ws), .i_cfg_parity_en(cfg_pe),
        .i_cfg_parity_odd(cfg_po), .i_cfg_two_stop(cfg_ts), .rx_bus(bus),
        .o_break(brk), .o_overrun(overrun), .o_busy(busy)
    );

    typedef struct {
        logic [MW-1:0] d;
        logic          pe;
        logic          fe;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0, n_pass = 0;
    int   brk_seen = 0, brk_exp = 0;
    int   m_ws = 8;
    bit   m_pe = 1'b0, m_po = 1'b0, m_ts = 1'b0;
    int   cal = 0;

    always #5 clk = ~clk;

    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick = ~tick;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: compare every accepted word against the queue and count break pulses.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (brk === 1'b1) brk_seen++;
            if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_word", {23'd0, bus.o_data}, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk("word_data", {23'd0, bus.o_data}, {23'd0, e.d});
                    chk("word_parity_err", {31'd0, bus.o_parity_err}, {31'd0, e.pe});
                    chk("word_frame_err", {31'd0, bus.o_frame_err}, {31'd0, e.fe});
                end
            end
        end
    end

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic set_cfg(input int ws, input bit pe, input bit po, input bit ts);
        cfg_ws = 5'(ws); cfg_pe = pe; cfg_po = po; cfg_ts = ts;
        cfg_store = 1'b1;
        @(posedge clk);
        #1 cfg_store = 1'b0;
        m_ws = (ws < 5) ? 5 : ((ws > MW) ? MW : ws);
        m_pe = pe; m_po = po; m_ts = ts;
        ticks(1);
    endtask

    task automatic drive_bit(input bit v, input bit glitch);
        int g;
        if (!glitch) begin
            rx = v;
            ticks(OS);
        end else begin
            g = 7 + int'($urandom % 3);
            rx = v;
            ticks(g);
            rx = ~v;
            ticks(1);
            rx = v;
            ticks(OS - g - 1);
        end
    endtask

    // Issue one frame under the model config; the expected outcome is queued first.
    task automatic send_frame(input logic [31:0] d, input bit pwrong, input bit s1,
                              input bit s2, input int gbit, input bit nopush,
                              input bit idle_lvl, input int gap);
        logic [MW-1:0] dm;
        bit            pbit;
        exp_t          e;
        dm   = MW'(d & ((32'd1 << m_ws) - 32'd1));
        pbit = m_po ^ bit'($countones(dm) % 2) ^ pwrong;
        if (dm == '0 && (!m_pe || !pbit) && !s1) begin
            brk_exp++;
        end else if (!nopush) begin
            e.d  = dm;
            e.pe = m_pe && ((($countones(dm) + int'(pbit)) % 2) != int'(m_po));
            e.fe = !s1 || (m_ts && !s2);
            sb_q.push_back(e);
        end
        rx = 1'b0;
        ticks(OS);
        for (int i = 0; i < m_ws; i++) drive_bit(dm[i], i == gbit);
        if (m_pe) drive_bit(pbit, 1'b0);
        drive_bit(s1, 1'b0);
        if (m_ts) drive_bit(s2, 1'b0);
        rx = idle_lvl;
        if (gap > 0) ticks(gap);
    endtask

    initial begin
        rst_n = 1'b0; rx = 1'b1; cfg_store = 1'b0; cfg_ws = 5'd0;
        cfg_pe = 1'b0; cfg_po = 1'b0; cfg_ts = 1'b0; bus.i_ready = 1'b0;
        ticks(4);
        chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst_data", {23'd0, bus.o_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_break", {31'd0, brk}, 32'd0);
        rst_n = 1'b1;
        ticks(4);

        // 8N1 default, word held while not ready, released by a one-cycle ready pulse.
        send_frame(32'hA5, 0, 1, 1, -1, 0, 1, 4);
        chk("hold_valid", {31'd0, bus.o_valid}, 32'd1);
        chk("hold_data", {23'd0, bus.o_data}, 32'h0A5);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        ticks(30);
        chk("hold_data_stable", {23'd0, bus.o_data}, 32'h0A5);
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1 bus.i_ready = 1'b0;
        chk("valid_drop_after_accept", {31'd0, bus.o_valid}, 32'd0);
        ticks(1);
        bus.i_ready = 1'b1;

        // 7 bits, odd parity, two stops: good then bad parity.
        set_cfg(7, 1, 1, 1);
        send_frame(32'h55, 0, 1, 1, -1, 0, 1, 3);
        send_frame(32'h55, 1, 1, 1, -1, 0, 1, 3);

        // 9-bit frame with low stop, line kept low: delivered with frame error.
        set_cfg(9, 0, 0, 0);
        send_frame(32'h1C3, 0, 0, 1, -1, 0, 0, 20);
        chk("wait_idle_busy", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        ticks(4);
        chk("wait_idle_exit", {31'd0, busy}, 32'd0);

        // Break: line low for two frame times.
        set_cfg(8, 0, 0, 0);
        send_frame(32'h0, 0, 0, 0, -1, 0, 0, 10 * OS);
        rx = 1'b1;
        ticks(4);
        chk("break_count", brk_seen, brk_exp);
        chk("break_no_word", {31'd0, bus.o_valid}, 32'd0);

        // False start, then a glitched data bit.
        rx = 1'b0;
        ticks(4);
        rx = 1'b1;
        ticks(30);
        chk("false_start_busy", {31'd0, busy}, 32'd0);
        chk("false_start_valid", {31'd0, bus.o_valid}, 32'd0);
        send_frame(32'h96, 0, 1, 1, 3, 0, 1, 3);

        // Overrun: second word dropped, flag cleared by acceptance.
        bus.i_ready = 1'b0;
        send_frame(32'h11, 0, 1, 1, -1, 0, 1, 3);
        send_frame(32'h22, 0, 1, 1, -1, 1, 1, 3);
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        chk("overrun_keeps_first", {23'd0, bus.o_data}, 32'h011);
        bus.i_ready = 1'b1;
        ticks(2);
        chk("overrun_cleared", {31'd0, overrun}, 32'd0);

        // Completion coinciding with acceptance: time the ready pulse from a reference frame.
        fork
            send_frame(32'h33, 0, 1, 1, -1, 0, 1, 3);
            begin
                int c;
                c = 0;
                while (busy !== 1'b1 && c < 2000) begin @(negedge clk); c++; end
                while (busy !== 1'b0 && c < 2000) begin @(negedge clk); c++; end
                cal = c;
            end
        join
        chk("calibration_found", {31'd0, cal < 2000}, 32'd1);
        bus.i_ready = 1'b0;
        send_frame(32'h44, 0, 1, 1, -1, 0, 1, 3);
        fork
            send_frame(32'h5A, 0, 1, 1, -1, 0, 1, 3);
            begin
                repeat (cal - 2) @(posedge clk);
                #1 bus.i_ready = 1'b1;
                @(posedge clk);
                #1 bus.i_ready = 1'b0;
            end
        join
        chk("same_cycle_no_overrun", {31'd0, overrun}, 32'd0);
        chk("same_cycle_new_word", {23'd0, bus.o_data}, 32'h05A);
        bus.i_ready = 1'b1;
        ticks(2);

        // Word size clamp to 5, and a config store mid-frame that must be ignored.
        set_cfg(3, 0, 0, 0);
        send_frame(32'h1F6, 0, 1, 1, -1, 0, 1, 3);
        fork
            send_frame(32'h0B, 0, 1, 1, -1, 0, 1, 3);
            begin
                ticks(40);
                cfg_ws = 5'd9; cfg_pe = 1'b1; cfg_po = 1'b1; cfg_ts = 1'b1;
                cfg_store = 1'b1;
                @(posedge clk);
                #1 cfg_store = 1'b0;
            end
        join
        send_frame(32'h1D, 0, 1, 1, -1, 0, 1, 3);

        // Reset in the middle of a data bit with a held word and overrun pending.
        set_cfg(7, 1, 0, 1);
        bus.i_ready = 1'b0;
        send_frame(32'h15, 0, 1, 1, -1, 1, 1, 3);
        send_frame(32'h2A, 0, 1, 1, -1, 1, 1, 3);
        chk("pre_reset_overrun", {31'd0, overrun}, 32'd1);
        rx = 1'b0;
        ticks(OS + 2 * OS + 5);
        rst_n = 1'b0;
        ticks(2);
        chk("mid_reset_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("mid_reset_data", {23'd0, bus.o_data}, 32'd0);
        chk("mid_reset_overrun", {31'd0, overrun}, 32'd0);
        chk("mid_reset_busy", {31'd0, busy}, 32'd0);
        rx = 1'b1;
        ticks(2);
        rst_n = 1'b1;
        bus.i_ready = 1'b1;
        m_ws = 8; m_pe = 1'b0; m_po = 1'b0; m_ts = 1'b0;
        ticks(4);
        send_frame(32'hC3, 0, 1, 1, -1, 0, 1, 3);

        // Randomised frames across configurations.
        for (int k = 0; k < 30; k++) begin
            logic [31:0] d;
            set_cfg(4 + int'($urandom % 7), bit'($urandom % 2), bit'($urandom % 2),
                    bit'($urandom % 2));
            d = ($urandom % 6 == 0) ? 32'd0 : $urandom;
            send_frame(d, ($urandom % 4) == 0, ($urandom % 8) != 0, ($urandom % 8) != 0,
                       ($urandom % 2 == 0) ? int'($urandom % 9) : -1, 0, 1,
                       2 + int'($urandom % 4));
        end

        for (int w = 0; w < 200 && sb_q.size() != 0; w++) ticks(1);
        chk("queue_drained", sb_q.size(), 32'd0);
        chk("break_total", brk_seen, brk_exp);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
